keypad_entry_fnd_ctrl: RTL and testbench

- Sequences key entry from the keypad scanner into an 8-digit decimal buffer.
- Time-multiplexes that buffer across the 8-digit FND through `fnd_scan`/`fnd_data`.
- Sits between `keypad_scan`, which provides the key code plus a one-cycle valid strobe, and the FND pins.
- Delivers a committed 8-digit BCD value on ENTER.

---
 rtl/keypad_entry_fnd_ctrl.sv | 133 +++++++++++++
 tb/tb_keypad_entry_fnd_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_fnd_ctrl.sv
// Keypad digit entry into an 8-digit BCD buffer with a multiplexed 7-segment FND scan.
// Define FND_LEADING_ZERO_BLANK_EN to blank digits beyond the entered length.
module keypad_entry_fnd_ctrl #(
  parameter int unsigned SCAN_DIV = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic [7:0]  fnd_scan,
  output logic [7:0]  fnd_data,
  output logic [31:0] entry,
  output logic        entry_valid
);

  typedef enum logic [4:0] {
    KEY_CLR   = 5'd10,
    KEY_BS    = 5'd11,
    KEY_ENTER = 5'd12
  } key_cmd_e;

  localparam logic [19:0] DIV_LAST = 20'(SCAN_DIV - 1);

  logic [31:0] buf_q, buf_d;
  logic [3:0]  len_q, len_d;
  logic [19:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  fnd_scan_q, fnd_scan_d;
  logic [7:0]  fnd_data_q, fnd_data_d;
  logic [31:0] entry_q, entry_d;
  logic        entry_valid_q, entry_valid_d;
  logic [3:0]  nib;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    buf_d         = buf_q;
    len_d         = len_q;
    entry_d       = entry_q;
    entry_valid_d = 1'b0;
    if (key_valid) begin
      if (key_code <= 5'd9) begin
        if (len_q < 4'd8) begin
          buf_d = {buf_q[27:0], key_code[3:0]};
          len_d = len_q + 4'd1;
        end
      end else begin
        case (key_code)
          KEY_CLR: begin
            buf_d = '0;
            len_d = '0;
          end
          KEY_BS: begin
            if (len_q != 4'd0) begin
              buf_d = {4'h0, buf_q[31:4]};
              len_d = len_q - 4'd1;
            end
          end
          KEY_ENTER: begin
            entry_d       = buf_q;
            entry_valid_d = 1'b1;
            buf_d         = '0;
            len_d         = '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Display uses the pre-update buffer, so a key shows up on the edge after it lands.
  always_comb begin
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + 3'd1;
    end else begin
      div_d = div_q + 20'd1;
      idx_d = idx_q;
    end
    nib        = buf_q[{idx_d, 2'b00} +: 4];
    fnd_scan_d = 8'h01 << idx_d;
    fnd_data_d = seg7(nib);
`ifdef FND_LEADING_ZERO_BLANK_EN
    if ({1'b0, idx_d} >= len_q) begin
      fnd_data_d = (len_q == 4'd0 && idx_d == 3'd0) ? 8'h3F : 8'h00;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q         <= '0;
      len_q         <= '0;
      div_q         <= '0;
      idx_q         <= '0;
      fnd_scan_q    <= 8'h01;
      fnd_data_q    <= 8'h00;
      entry_q       <= '0;
      entry_valid_q <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      len_q         <= len_d;
      div_q         <= div_d;
      idx_q         <= idx_d;
      fnd_scan_q    <= fnd_scan_d;
      fnd_data_q    <= fnd_data_d;
      entry_q       <= entry_d;
      entry_valid_q <= entry_valid_d;
    end
  end

  assign fnd_scan    = fnd_scan_q;
  assign fnd_data    = fnd_data_q;
  assign entry       = entry_q;
  assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_keypad_entry_fnd_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs from a digit-queue model; a monitor pops and compares.
module tb_keypad_entry_fnd_ctrl;

  localparam int SD = 4;
  localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic [7:0]  fnd_scan, fnd_data;
  logic [31:0] entry;
  logic        entry_valid;

  keypad_entry_fnd_ctrl #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .fnd_scan(fnd_scan), .fnd_data(fnd_data), .entry(entry), .entry_valid(entry_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  scan;
    logic [7:0]  data;
    logic [31:0] ent;
    logic        ev;
  } exp_t;

  exp_t        disp_q[$];
  logic [31:0] ent_q[$];

  // Reference model: digits[0] is the rightmost (most recently typed) digit.
  int          digits[$];
  int          k;
  logic [31:0] committed;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] buf_value();
    logic [31:0] v = '0;
    for (int i = 0; i < digits.size(); i++) v = v | (32'(digits[i]) << (4 * i));
    return v;
  endfunction

  function automatic logic [7:0] model_seg(input int pos);
    int d;
    d = (pos < digits.size()) ? digits[pos] : 0;
`ifdef FND_LEADING_ZERO_BLANK_EN
    if (pos >= digits.size()) return (digits.size() == 0 && pos == 0) ? 8'h3F : 8'h00;
`endif
    return SEG[d];
  endfunction

  task automatic step(input bit r, input bit kv, input int code);
    exp_t e;
    int pos;
    @(negedge clk);
    rst       = r;
    key_valid = kv;
    key_code  = code[4:0];
    e.ev = 1'b0;
    if (r) begin
      e.scan = 8'h01;
      e.data = 8'h00;
      digits.delete();
      k = 0;
      committed = '0;
    end else begin
      k++;
      pos    = (k / SD) % 8;
      e.scan = 8'h01 << pos;
      e.data = model_seg(pos);
      if (kv) begin
        if (code <= 9) begin
          if (digits.size() < 8) digits.push_front(code);
        end else if (code == 10) begin
          digits.delete();
        end else if (code == 11) begin
          if (digits.size() > 0) void'(digits.pop_front());
        end else if (code == 12) begin
          committed = buf_value();
          ent_q.push_back(committed);
          digits.delete();
          e.ev = 1'b1;
        end
      end
    end
    e.ent = committed;
    disp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, int'($urandom_range(0, 31)));
  endtask

  task automatic key(input int c);
    step(1'b0, 1'b1, c);
    idle(int'($urandom_range(0, 2)));
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] ev_exp;
    forever begin
      @(posedge clk);
      #1;
      if (disp_q.size() > 0) begin
        e = disp_q.pop_front();
        chk("fnd_scan", 32'(fnd_scan), 32'(e.scan));
        chk("fnd_data", 32'(fnd_data), 32'(e.data));
        chk("entry_valid", 32'(entry_valid), 32'(e.ev));
        chk("entry_hold", entry, e.ent);
        if (entry_valid === 1'b1) begin
          if (ent_q.size() == 0) begin
            chk("entry_unexpected_pulse", 32'(entry_valid), 32'd0);
          end else begin
            ev_exp = ent_q.pop_front();
            chk("entry_value", entry, ev_exp);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b1, 3);
    idle(40);
    key(1); key(2); key(3);
    idle(40);
    for (int d = 1; d <= 9; d++) key(d);
    idle(33);
    key(11);
    idle(10);
    for (int i = 0; i < 8; i++) key(11);
    idle(10);
    key(4); key(2);
    step(1'b0, 1'b1, 12);
    step(1'b0, 1'b1, 12);
    idle(5);
    key(7); key(15); key(10);
    idle(5);
    key(9); key(8);
    step(1'b1, 1'b1, 5);
    idle(12);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b1, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 31)));
      end else if ($urandom_range(0, 2) == 0) begin
        r = int'($urandom_range(0, 15));
        if (r >= 13) r = int'($urandom_range(13, 31));
        step(1'b0, 1'b1, r);
      end else begin
        step(1'b0, 1'b0, int'($urandom_range(0, 31)));
      end
    end
    idle(2);
    @(posedge clk);
    #2;
    chk("disp_queue_drained", 32'(disp_q.size()), 32'd0);
    chk("entry_queue_drained", 32'(ent_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
